// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
//   Source-domain transmitter for a 4-phase req/ack clock-domain-crossing handshake.
//   A word accepted on send_valid/send_ready is registered onto data_out and held stable
//   while req_out is raised. The destination acknowledges on ack_in, which is
//   resynchronised here through SYNC_STAGES flops before the FSM looks at it. The
//   handshake completes once the synchronised ack has been seen high and then low
//   again, and done pulses for one enabled cycle.
//
//   Optional feature (macro CDC_HANDSHAKE_TX_TIMEOUT_EN): each handshake phase is
//   aborted after TIMEOUT_CYCLES enabled cycles, with a one-cycle pulse on timeout.
//   Without the macro no counter is built and timeout is tied low.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset (overrides en)
//   en          clock enable; when low all state, counters and sync stages hold
//   send_valid  source requests transfer of send_data
//   send_data   word to transfer
//   send_ready  block can accept a word this cycle
//   done        one-cycle pulse: handshake completed
//   req_out     registered request to the destination domain
//   data_out    registered data to the destination domain
//   ack_in      asynchronous acknowledge from the destination domain
//   busy        handshake in progress
//   timeout     one-cycle pulse: phase aborted (optional feature, else 0)

module cdc_handshake_tx #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned SYNC_STAGES    = 3,    // legal 2..4
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             send_valid,
    input  logic [WIDTH-1:0] send_data,
    output logic             send_ready,
    output logic             done,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReqHi = 2'd1,
        StReqLo = 2'd2
    } state_e;

    state_e                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    // ack_in feeds stage 0 directly; nothing combinational may sit in front of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync <= '0;
        end else if (en) begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // A new request must wait until the previous ack has been seen low, otherwise a
    // stale ack would complete the next handshake prematurely.
    assign send_ready = (state == StIdle) && !ack_s && !reset;
    assign busy       = (state != StIdle);

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    // The counter is cleared on entry to a phase, so the phase has waited
    // TIMEOUT_CYCLES enabled cycles at the edge where it holds TIMEOUT_CYCLES-1.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] phase_cnt;
    logic            aborted;
    logic            timeout_q;
    logic            expired;

    assign expired = (phase_cnt == CntLast);
    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            req_out  <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
            phase_cnt <= '0;
            aborted   <= 1'b0;
            timeout_q <= 1'b0;
`endif
        end else if (en) begin
            done <= 1'b0;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (send_valid && send_ready) begin
                        data_out <= send_data;
                        req_out  <= 1'b1;
                        state    <= StReqHi;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
                        phase_cnt <= '0;
                        aborted   <= 1'b0;
`endif
                    end
                end

                StReqHi: begin
                    if (ack_s) begin
                        req_out <= 1'b0;
                        state   <= StReqLo;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
                        phase_cnt <= '0;
`endif
                    end
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
                    else if (expired) begin
                        req_out   <= 1'b0;
                        timeout_q <= 1'b1;
                        aborted   <= 1'b1;
                        state     <= StReqLo;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
`endif
                end

                StReqLo: begin
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
                    // After an abort a late ack may still be in flight, so the low phase
                    // is sat out for a full timeout window and never reports done.
                    if (!ack_s && !aborted) begin
                        state     <= StIdle;
                        done      <= 1'b1;
                        phase_cnt <= '0;
                    end else if (expired) begin
                        state     <= StIdle;
                        timeout_q <= 1'b1;
                        aborted   <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
`else
                    if (!ack_s) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end
`endif
                end

                default: begin
                    state   <= StIdle;
                    req_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx
//   Self-checking bench for cdc_handshake_tx (WIDTH=8, SYNC_STAGES=3, TIMEOUT_CYCLES=15).
//   Table-driven full handshakes with latency checks, hand-written corner sequences
//   (spurious ack, reset mid-handshake, timeout or indefinite wait) and a randomised run
//   against a transaction-level reference model.

module tb_cdc_handshake_tx;

    localparam int SYNC = 3;

    logic       clk;
    logic       reset;
    logic       en;
    logic       send_valid;
    logic [7:0] send_data;
    logic       send_ready;
    logic       done;
    logic       req_out;
    logic [7:0] data_out;
    logic       ack_in;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    cdc_handshake_tx #(
        .WIDTH         (8),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .send_valid(send_valid),
        .send_data (send_data),
        .send_ready(send_ready),
        .done      (done),
        .req_out   (req_out),
        .data_out  (data_out),
        .ack_in    (ack_in),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset      = 1'b1;
        en         = 1'b0;
        send_valid = 1'b0;
        send_data  = 8'h00;
        ack_in     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        en    = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         rise_dly;      // clk cycles from req_out rise to ack_in rise
        int         fall_dly;      // clk cycles from req_out fall to ack_in fall
        bit         toggle;        // en toggles 1/0 every cycle
        int         exp_rise;      // cycle of req_out rise after accept edge count
        int         exp_req_fall;  // cycles from ack_in rise to req_out fall
        int         exp_done;      // cycles from ack_in fall to done
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int cyc       = 0;
        int t_rise    = -1;
        int t_fall    = -1;
        int t_arise   = -1;
        int t_afall   = -1;
        int t_done    = -1;
        int done_cnt  = 0;
        int hold_err  = 0;
        int ready_err = 0;
        bit prev_req  = 1'b0;
        bit prev_done = 1'b0;
        string tag;
        tag        = $sformatf("vec%0d", idx);
        ack_in     = 1'b0;
        en         = 1'b1;
        send_valid = 1'b1;
        send_data  = v.data;
        #1;
        check({tag, "_ready_c0"}, send_ready, 1);
        while (cyc < 200 && !(t_done >= 0 && cyc >= t_done + 6)) begin
            tick();
            cyc++;
            if (req_out && !prev_req && t_rise < 0) t_rise = cyc;
            if (!req_out && prev_req) t_fall = cyc;
            if (done && !prev_done) begin
                done_cnt++;
                if (t_done < 0) t_done = cyc;
            end
            if (busy && data_out !== v.data) hold_err++;
            if (busy && send_ready) ready_err++;
            prev_req  = req_out;
            prev_done = done;
            // Keep offering a different word while busy: it must be ignored.
            if (t_rise >= 0 && t_done < 0) begin
                send_valid = 1'b1;
                send_data  = ~v.data;
            end
            if (t_done >= 0) send_valid = 1'b0;
            if (t_rise >= 0 && t_arise < 0 && req_out && cyc - t_rise == v.rise_dly) begin
                ack_in  = 1'b1;
                t_arise = cyc;
            end
            if (t_fall >= 0 && t_afall < 0 && !req_out && cyc - t_fall == v.fall_dly) begin
                ack_in  = 1'b0;
                t_afall = cyc;
            end
            en = v.toggle ? ~en : 1'b1;
        end
        check({tag, "_req_rise"}, t_rise, v.exp_rise);
        check({tag, "_req_fall_lat"}, t_fall - t_arise, v.exp_req_fall);
        check({tag, "_done_lat"}, t_done - t_afall, v.exp_done);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_data_hold"}, hold_err, 0);
        check({tag, "_ready_busy"}, ready_err, 0);
        check({tag, "_data_final"}, data_out, v.data);
        check({tag, "_ready_end"}, send_ready, 1);
    endtask

    // Reference model state: handshake outstanding / request level / captured word.
    bit       m_pending;
    bit       m_req;
    bit       m_done;
    bit [7:0] m_data;
    bit       m_hist[$];   // ack_in as sampled on the last SYNC enabled edges, newest first

    task automatic model_reset();
        m_pending = 1'b0;
        m_req     = 1'b0;
        m_done    = 1'b0;
        m_data    = 8'h00;
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    endtask

    // Applies one clock edge to the model; returns 1 when a word was accepted.
    function automatic bit model_edge(input bit a_en, input bit a_sv, input bit [7:0] a_sd,
                                      input bit a_ack);
        bit acc = 1'b0;
        bit seen;
        if (!a_en) return 1'b0;
        seen   = m_hist[SYNC-1];
        m_done = 1'b0;
        if (!m_pending) begin
            if (a_sv && !seen) begin
                m_pending = 1'b1;
                m_req     = 1'b1;
                m_data    = a_sd;
                acc       = 1'b1;
            end
        end else if (m_req) begin
            if (seen) m_req = 1'b0;
        end else if (!seen) begin
            m_pending = 1'b0;
            m_done    = 1'b1;
        end
        m_hist.push_front(a_ack);
        void'(m_hist.pop_back());
        return acc;
    endfunction

    initial begin
        vec_t vecs[5];
        int   cnt;
        int   bad;
        int   t1;
        int   t2;
        int   dcnt;
        int   dly;
        bit   acc;
        bit   a_en;
        bit   a_sv;
        bit   a_ack;
        bit [7:0] a_sd;

        vecs[0] = '{data: 8'hA5, rise_dly: 2, fall_dly: 2, toggle: 1'b0,
                    exp_rise: 1, exp_req_fall: 4, exp_done: 4};
        vecs[1] = '{data: 8'h3C, rise_dly: 1, fall_dly: 3, toggle: 1'b0,
                    exp_rise: 1, exp_req_fall: 4, exp_done: 4};
        vecs[2] = '{data: 8'hFF, rise_dly: 3, fall_dly: 1, toggle: 1'b0,
                    exp_rise: 1, exp_req_fall: 4, exp_done: 4};
        vecs[3] = '{data: 8'h5A, rise_dly: 2, fall_dly: 2, toggle: 1'b1,
                    exp_rise: 1, exp_req_fall: 8, exp_done: 8};
        vecs[4] = '{data: 8'h81, rise_dly: 4, fall_dly: 2, toggle: 1'b1,
                    exp_rise: 1, exp_req_fall: 8, exp_done: 8};

        // Reset with en low: reset must still win.
        reset_dut();
        reset = 1'b1;
        en    = 1'b0;
        #1;
        check("rst_ready", send_ready, 0);
        tick();
        check("rst_req", req_out, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        en    = 1'b1;
        #1;
        check("rst_ready_rel", send_ready, 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Spurious ack while idle: no request, ready returns SYNC cycles after ack drops.
        en         = 1'b1;
        send_valid = 1'b0;
        ack_in     = 1'b1;
        tick();
        tick();
        tick();
        check("spur_ready_lo", send_ready, 0);
        send_valid = 1'b1;
        send_data  = 8'h99;
        bad        = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_out || busy || done) bad++;
        end
        check("spur_no_req", bad, 0);
        ack_in = 1'b0;
        tick();
        tick();
        check("spur_ready_c2", send_ready, 0);
        tick();
        check("spur_ready_c3", send_ready, 1);
        tick();
        check("spur_accept_req", req_out, 1);
        check("spur_accept_data", data_out, 8'h99);

        // Reset while in REQ_HI, with en low.
        send_valid = 1'b0;
        tick();
        check("midrst_busy_pre", busy, 1);
        reset = 1'b1;
        en    = 1'b0;
        #1;
        check("midrst_ready", send_ready, 0);
        tick();
        check("midrst_req", req_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", data_out, 0);
        reset = 1'b0;
        en    = 1'b1;
        #1;
        check("midrst_ready_rel", send_ready, 1);

        // No ack ever: timeout behaviour, or an indefinite wait without the feature.
        send_valid = 1'b1;
        send_data  = 8'h42;
        tick();
        send_valid = 1'b0;
        check("to_req_hi", req_out, 1);
        t1   = -1;
        t2   = -1;
        dcnt = 0;
        bad  = 0;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) dcnt++;
            if (timeout) begin
                if (t1 < 0) begin
                    t1 = c;
                    if (req_out) bad++;
                end else if (t2 < 0) begin
                    t2 = c;
                end
            end
        end
        check("to_first", t1, 15);
        check("to_second", t2, 30);
        check("to_req_low", bad, 0);
        check("to_no_done", dcnt, 0);
        check("to_idle", busy, 0);
`else
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done || timeout || !req_out || !busy) bad++;
        end
        check("wait_forever", bad, 0);
        check("wait_data", data_out, 8'h42);
`endif

        // Randomised run against the reference model.
        reset_dut();
        model_reset();
        dly = 0;
        cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            en = ($urandom_range(0, 3) != 0);
            if (!send_valid && $urandom_range(0, 1) == 1) begin
                send_valid = 1'b1;
                send_data  = 8'($urandom);
            end
            if (req_out != ack_in) begin
                if (dly == 0) begin
                    ack_in = req_out;
                    dly    = $urandom_range(0, 3);
                end else begin
                    dly--;
                end
            end
            a_en  = en;
            a_sv  = send_valid;
            a_sd  = send_data;
            a_ack = ack_in;
            tick();
            acc = model_edge(a_en, a_sv, a_sd, a_ack);
            if (acc) begin
                send_valid = 1'b0;
                cnt++;
            end
            check("rnd_req", req_out, m_req);
            check("rnd_data", data_out, m_data);
            check("rnd_busy", busy, m_pending);
            check("rnd_done", done, m_done);
            check("rnd_ready", send_ready, !m_pending && !m_hist[SYNC-1]);
            check("rnd_timeout", timeout, 0);
        end
        n_cmp++;
        if (cnt < 20) begin
            n_err++;
            $display("FAIL rnd_progress: got %0d transfers, expected at least 20", cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
